// File: rtl/hex_replay_if.sv
// rtl/hex_replay_if.sv - pin bundle for hex_replay: UART input plus playback and status outputs
interface hex_replay_if;
  logic       fpga_rx;
  logic       sig_out;
  logic       busy;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       done;

  modport slave (
    input  fpga_rx,
    output sig_out, busy, rx_valid, rx_data, frame_err, done
  );

  modport master (
    output fpga_rx,
    input  sig_out, busy, rx_valid, rx_data, frame_err, done
  );
endinterface

// File: rtl/hex_replay.sv
// rtl/hex_replay.sv - UART-loaded 16-bit pattern buffer replayed bit-serially on sig_out
// Build option HEX_REPLAY_LOOP_EN: playback repeats until a new header byte arrives.
module hex_replay #(
  parameter int CLK_FREQ = 48000000,
  parameter int SYM_RATE = 1200,
  parameter int AW       = 8
) (
  input  logic        clk,
  input  logic        rst,
  hex_replay_if.slave io
);
  localparam int SYM_CNT = CLK_FREQ / SYM_RATE;
  localparam int SCW     = $clog2(SYM_CNT);
  localparam logic [SCW-1:0] HALF_M1 = SCW'(SYM_CNT / 2 - 1);
  localparam logic [SCW-1:0] FULL_M1 = SCW'(SYM_CNT - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI} rx_state_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD_HI, S_LOAD_LO, S_PLAY} state_t;
  typedef logic [AW:0] wcnt_t;

  rx_state_t      rx_state_q, rx_state_d;
  logic           rx_s1_q, rx_s2_q;
  logic [SCW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_sh_q, rx_sh_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           frame_err_q, frame_err_d;

  state_t         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  wcnt_t          n_q, n_d;
  wcnt_t          wleft_q, wleft_d;
  logic [7:0]     hi_q, hi_d;
  logic [15:0]    sh_q, sh_d;
  logic [3:0]     bit_q, bit_d;
  logic           shv_q, shv_d;
  logic           pend_q, pend_d;
  logic           done_q, done_d;

  logic           we, re;
  logic [AW-1:0]  ra;
  logic [15:0]    ram_rdata_q;
  logic [15:0]    mem [0:(1<<AW)-1];
  wcnt_t          hdr_words;
  logic           last_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_s1_q     <= io.fpga_rx;
      rx_s2_q     <= rx_s1_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Start bit is re-checked at mid-bit; every later sample lands mid-bit too.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 1'b1;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
            rx_state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_WAIT_HI;
          end
        end
      end
      RX_WAIT_HI: begin
        rx_cnt_d = '0;
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      n_q     <= '0;
      wleft_q <= '0;
      hi_q    <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      shv_q   <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      wleft_q <= wleft_d;
      hi_q    <= hi_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      shv_q   <= shv_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    hdr_words = (rx_data_q == 8'd0) ? wcnt_t'(1 << AW) : wcnt_t'(rx_data_q);
    last_word = (wleft_q == wcnt_t'(1));
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    n_d     = n_q;
    wleft_d = wleft_q;
    hi_d    = hi_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    shv_d   = shv_q;
    pend_d  = 1'b0;
    done_d  = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    ra      = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid_q) begin
          n_d     = hdr_words;
          addr_d  = '0;
          state_d = S_LOAD_HI;
        end
      end
      S_LOAD_HI: begin
        if (frame_err_q) begin
          state_d = S_IDLE;
        end else if (rx_valid_q) begin
          hi_d    = rx_data_q;
          state_d = S_LOAD_LO;
        end
      end
      S_LOAD_LO: begin
        if (frame_err_q) begin
          state_d = S_IDLE;
        end else if (rx_valid_q) begin
          we = 1'b1;
          if (wcnt_t'(addr_q) + wcnt_t'(1) == n_q) begin
            addr_d  = '0;
            wleft_d = n_q;
            state_d = S_PLAY;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_LOAD_HI;
          end
        end
      end
      S_PLAY: begin
        if (!shv_q && !pend_q) begin
          re     = 1'b1;
          addr_d = addr_q + 1'b1;
          pend_d = 1'b1;
        end else if (pend_q) begin
          sh_d  = ram_rdata_q;
          shv_d = 1'b1;
          bit_d = '0;
        end else begin
          sh_d  = {sh_q[14:0], 1'b0};
          bit_d = bit_q + 1'b1;
          // Prefetch while bit 1 is on the pin so the next word is ready for a gapless reload.
          if (bit_q == 4'd14) begin
`ifdef HEX_REPLAY_LOOP_EN
            re = 1'b1;
            ra = last_word ? '0 : addr_q;
`else
            re = !last_word;
`endif
            addr_d = ra + 1'b1;
          end
          if (bit_q == 4'd15) begin
            if (!last_word) begin
              sh_d    = ram_rdata_q;
              wleft_d = wleft_q - 1'b1;
            end else begin
              done_d = 1'b1;
`ifdef HEX_REPLAY_LOOP_EN
              sh_d    = ram_rdata_q;
              wleft_d = n_q;
`else
              shv_d   = 1'b0;
              state_d = S_IDLE;
`endif
            end
          end
        end
`ifdef HEX_REPLAY_LOOP_EN
        if (rx_valid_q) begin
          re      = 1'b0;
          shv_d   = 1'b0;
          pend_d  = 1'b0;
          n_d     = hdr_words;
          addr_d  = '0;
          state_d = S_LOAD_HI;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr_q] <= {hi_q, rx_data_q};
    if (re) ram_rdata_q <= mem[ra];
  end

  assign io.sig_out   = shv_q & sh_q[15];
  assign io.busy      = (state_q != S_IDLE);
  assign io.rx_valid  = rx_valid_q;
  assign io.rx_data   = rx_data_q;
  assign io.frame_err = frame_err_q;
  assign io.done      = done_q;
endmodule

// File: doc/hex_replay.md
Name: hex_replay

Overview:
- Upload-and-playback companion to the sample capture/dump path. Receives a framed binary image over the UART RX line (fpga_rx) and stores it as 16-bit words in a block-RAM buffer.
- When the image is complete, replays the buffer bit-serially on sig_out at one bit per clk. The bench or the board can then drive the comparator/PWM path with recorded or synthetic patterns.
- Contains its own 8N1 receiver, a loader FSM and a playback shifter.

Parameters:
CLK_FREQ, 48000000, system clock in Hz
SYM_RATE, 1200, UART baud rate; SYM_CNT = CLK_FREQ/SYM_RATE, SCW = $clog2(SYM_CNT)
AW, 8, buffer address width; depth = 2**AW words of 16 bits

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
fpga_rx  in  1  UART serial input, idle high, 8N1, LSB first
sig_out  out  1  playback bit stream, MSB of each word first
busy  out  1  high in LOAD_HI, LOAD_LO or PLAY
rx_valid  out  1  one-cycle strobe: good byte received
rx_data  out  8  last good byte, valid while rx_valid
frame_err  out  1  one-cycle strobe: stop bit sampled low
done  out  1  one-cycle strobe: playback finished

Behaviour:
- Reset (async, active-high): all outputs 0, FSM IDLE, address and counters 0. Reset mid-load or mid-play abandons the image.
- RX front end: 2-FF synchronizer on fpga_rx, reset value 1.
- RX start: a falling edge starts the timer. At SYM_CNT/2 the line is re-sampled; if high, it is a false start and the receiver returns to idle with no strobe.
- RX data: 8 data bits sampled every SYM_CNT thereafter, LSB first, then the stop bit.
- RX result: stop bit high -> rx_valid=1 for exactly 1 cycle, on the clk after the stop sample, with rx_data updated. Stop bit low -> frame_err=1 for 1 cycle, rx_data unchanged, byte discarded. After a frame error the receiver rearms only after seeing the line high.
- Frame format: header byte N gives the word count, with 0 meaning 2**AW (with AW=8, 1..255 map to 1..255 words and 0 to 256). Header is followed by 2N bytes, high byte then low byte per word.
- FSM IDLE: rx_valid -> latch N, addr=0 -> LOAD_HI.
- FSM LOAD_HI: rx_valid -> hold byte -> LOAD_LO.
- FSM LOAD_LO: rx_valid -> write {hi,lo} at addr. If this was word N-1 -> PLAY; else addr+1 -> LOAD_HI.
- FSM PLAY: reads word 0 the cycle after entry. Word 0 bit15 appears on sig_out exactly 3 clks after the final rx_valid.
- Playback timing: bits are emitted continuously with no gap between words; the next word is prefetched during bit 1 of the current word (1-cycle RAM read latency).
- Playback end: exactly 16*N cycles of data. On the cycle after the last bit, done=1, sig_out=0, FSM -> IDLE.
- frame_err in LOAD_HI/LOAD_LO: abort to IDLE, buffer contents undefined.
- rx_valid during PLAY: the byte is ignored; playback continues.
- rx_valid and a frame_err never coincide; the receiver produces one result per frame.
- Address arithmetic is AW bits and wraps naturally. The word counter is AW+1 bits so that N=0 yields 2**AW words.
- Buffer: one inferred or SB_RAM40_4K 16-bit-wide RAM, synchronous read and write; write and read never target the same cycle.

Optional Feature:
- Macro HEX_REPLAY_LOOP_EN.
- Defined: at the end of PLAY, addr returns to 0 and playback repeats seamlessly, with no gap between the last bit and word 0 bit15. done pulses at each wrap. Any rx_valid during PLAY stops playback at once (sig_out=0) and is treated as a new header (-> LOAD_HI with new N).
- Undefined: single-shot playback as above; bytes during PLAY are ignored.

Test Plan:
- CLK_FREQ=16, SYM_RATE=1 (SYM_CNT=16), single byte 0xA5 with good stop -> one rx_valid pulse, rx_data=0xA5, busy rises to 1 (header accepted).
- Header 0x01, then 0xA5, 0x0F -> sig_out exactly 1010010100001111 starting 3 clks after the last rx_valid. done pulse on cycle 17 after the first bit; busy=0 and sig_out=0 afterwards.
- Header 0x02, words 0xFFFF, 0x0000 -> 16 ones then 16 zeros with no gap or glitch at the word boundary.
- Byte 0x3C with the stop bit held low -> frame_err pulse, no rx_valid, FSM stays IDLE. A following 0x01 header is accepted normally.
- fpga_rx low for 4 clks (less than SYM_CNT/2) -> no rx_valid, no frame_err. Header 0x00 plus 512 bytes -> 4096 playback cycles, one done pulse.
- Assert rst for 1 clk after the hi byte of word 3 of a 5-word load -> all outputs 0 immediately. A fresh header 0x01 plus 2 bytes then plays correctly. With HEX_REPLAY_LOOP_EN: N=1 pattern repeats, done every 16 clks, and a new byte aborts playback.
